instr_fetch: RTL

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch.sv | 120 ++++++++++++
 1 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch/sequencer: 16x8 program store, IDLE/FETCH/EXEC/HALT control,
// presents each datapath instruction to the decoder for EXEC_CYC cycles.
module instr_fetch #(
    parameter int unsigned EXEC_CYC = 2,
    parameter logic [7:0]  MEM_INIT = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       prog_we,
    input  logic [3:0] prog_addr,
    input  logic [7:0] prog_data,
    input  logic       start,
    input  logic       zero_flag,
    output logic [7:0] instr,
    output logic       instr_valid,
    output logic [3:0] pc,
    output logic       busy,
    output logic       halted
);

    localparam int unsigned CW = 3;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_EXEC  = 2'd2;
    localparam logic [1:0] S_HALT  = 2'd3;

    localparam logic [3:0] OP_JZ  = 4'hD;
    localparam logic [3:0] OP_JMP = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam logic [CW-1:0] LAST_CNT = CW'(EXEC_CYC - 1);

    // Power-up contents only; rst deliberately leaves the program intact.
    logic [7:0] mem [16] = '{default: MEM_INIT};

    logic [1:0]    state, state_nxt;
    logic [7:0]    ir, ir_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [3:0]    pc_nxt;
    logic [7:0]    instr_nxt;
    logic          valid_nxt;
    logic [7:0]    fetch_word;
    logic          fetch_dp;

    always_comb begin
        fetch_word = mem[pc];
        fetch_dp   = !(fetch_word[7:4] inside {OP_JZ, OP_JMP, OP_HLT});
    end

    // Program writes are only accepted while the sequencer is parked.
    always_ff @(posedge clk) begin
        if (prog_we && (state == S_IDLE || state == S_HALT)) begin
            mem[prog_addr] <= prog_data;
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        ir_nxt    = ir;
        cnt_nxt   = cnt;
        instr_nxt = instr;
        valid_nxt = instr_valid;
        case (state)
            S_IDLE, S_HALT: begin
                if (start) begin
                    pc_nxt    = 4'd0;
                    state_nxt = S_FETCH;
                end
            end
            S_FETCH: begin
                ir_nxt    = fetch_word;
                cnt_nxt   = '0;
                valid_nxt = fetch_dp;
                instr_nxt = fetch_dp ? fetch_word : 8'h00;
                state_nxt = S_EXEC;
            end
            S_EXEC: begin
                cnt_nxt = cnt + 1'b1;
                if (cnt == LAST_CNT) begin
                    instr_nxt = 8'h00;
                    valid_nxt = 1'b0;
                    state_nxt = S_FETCH;
                    // Branch resolution uses zero_flag as seen on the final EXEC cycle.
                    case (ir[7:4])
                        OP_JMP:  pc_nxt = ir[3:0];
                        OP_JZ:   pc_nxt = zero_flag ? ir[3:0] : pc + 4'd1;
                        OP_HLT:  state_nxt = S_HALT;
                        default: pc_nxt = pc + 4'd1;
                    endcase
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            pc          <= 4'd0;
            ir          <= 8'h00;
            cnt         <= '0;
            instr       <= 8'h00;
            instr_valid <= 1'b0;
            busy        <= 1'b0;
            halted      <= 1'b0;
        end else begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            ir          <= ir_nxt;
            cnt         <= cnt_nxt;
            instr       <= instr_nxt;
            instr_valid <= valid_nxt;
            busy        <= (state_nxt == S_FETCH) || (state_nxt == S_EXEC);
            halted      <= (state_nxt == S_HALT);
        end
    end

endmodule
